// File: rtl/vrf_pkg.sv
// Shared VRF write-path types and width helpers, used by the write arbiter
// and by every requester that builds write requests.
package vrf_pkg;

  localparam int VRF_MEM_DEPTH = 512;
  localparam int VRF_MEM_WIDTH = 32;

  function automatic int vrf_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int vrf_nb(input int width);
    return width / 8;
  endfunction

  localparam int VRF_AW = vrf_aw(VRF_MEM_DEPTH);
  localparam int VRF_NB = vrf_nb(VRF_MEM_WIDTH);

  // Field widths follow the lane's default VRF geometry.
  typedef struct packed {
    logic [VRF_AW-1:0]        addr;
    logic [VRF_NB-1:0]        bwe;
    logic [VRF_MEM_WIDTH-1:0] data;
  } vrf_wr_req_t;

endpackage

// File: rtl/vrf_wr_rr_select.sv
// Combinational rotate-scan: allocates write ports in round-robin order from
// i_ptr and refuses any requester whose address is already granted this cycle.
module vrf_wr_rr_select #(
  parameter int NUM_REQ     = 6,
  parameter int W_PORTS_NUM = 4,
  parameter int AW          = 9,
  parameter int NB          = 4,
  parameter int IW          = $clog2(NUM_REQ)
)(
  input  logic [IW-1:0]                      i_ptr,
  input  logic                               i_en,
  input  logic [NUM_REQ-1:0]                 i_valid,
  input  logic [NUM_REQ-1:0][AW-1:0]         i_addr,
  input  logic [NUM_REQ-1:0][NB-1:0]         i_bwe,
  output logic [NUM_REQ-1:0]                 o_grant,
  output logic [W_PORTS_NUM-1:0]             o_port_vld,
  output logic [W_PORTS_NUM-1:0][IW-1:0]     o_port_idx,
  output logic [IW-1:0]                      o_last_idx,
  output logic                               o_any_port,
  output logic                               o_collision
);

  logic [NUM_REQ-1:0] w_taken;
  logic [IW-1:0]      w_idx;
  logic [AW-1:0]      w_addr;
  logic               w_hit;
  int                 w_nused;

  always_comb begin
    o_grant     = '0;
    o_port_vld  = '0;
    o_port_idx  = '0;
    o_last_idx  = '0;
    o_any_port  = 1'b0;
    o_collision = 1'b0;
    w_taken     = '0;
    w_nused     = 0;
    w_idx       = '0;
    w_addr      = '0;
    w_hit       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx  = (int'(i_ptr) + k >= NUM_REQ) ? IW'(int'(i_ptr) + k - NUM_REQ)
                                            : IW'(int'(i_ptr) + k);
      w_addr = i_addr[w_idx];
      w_hit  = 1'b0;
      for (int j = 0; j < NUM_REQ; j++)
        if (w_taken[j] && i_addr[j] == w_addr) w_hit = 1'b1;
      // Zero-bwe writes are no-ops: accept them without spending a port.
      if (i_en && i_valid[w_idx]) begin
        if (i_bwe[w_idx] == '0) begin
          o_grant[w_idx] = 1'b1;
        end else if (w_nused < W_PORTS_NUM) begin
          if (w_hit) begin
            o_collision = 1'b1;
          end else begin
            o_grant[w_idx] = 1'b1;
            w_taken[w_idx] = 1'b1;
            for (int p = 0; p < W_PORTS_NUM; p++)
              if (p == w_nused) begin
                o_port_vld[p] = 1'b1;
                o_port_idx[p] = w_idx;
              end
            o_last_idx = w_idx;
            o_any_port = 1'b1;
            w_nused    = w_nused + 1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/vrf_wr_arbiter.sv
// Round-robin VRF write-port arbiter: one registered stage between the
// requesters and the VRF write ports, plus a collision-stall counter.
module vrf_wr_arbiter
  import vrf_pkg::*;
#(
  parameter int  NUM_REQ     = 6,
  parameter int  W_PORTS_NUM = 4,
  parameter int  MEM_DEPTH   = VRF_MEM_DEPTH,
  parameter int  MEM_WIDTH   = VRF_MEM_WIDTH,
  localparam int AW          = vrf_aw(MEM_DEPTH),
  localparam int NB          = vrf_nb(MEM_WIDTH)
)(
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                arb_en_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0][AW-1:0]          req_addr_i,
  input  logic [NUM_REQ-1:0][NB-1:0]          req_bwe_i,
  input  logic [NUM_REQ-1:0][MEM_WIDTH-1:0]   req_data_i,
  output logic [W_PORTS_NUM-1:0][AW-1:0]      vrf_waddr_o,
  output logic [W_PORTS_NUM-1:0][NB-1:0]      vrf_bwe_o,
  output logic [W_PORTS_NUM-1:0][MEM_WIDTH-1:0] vrf_din_o,
  output logic [15:0]                         conflict_cnt_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0]     r_ptr;
  logic [15:0]       r_cnt;
  vrf_wr_req_t       r_port [W_PORTS_NUM];

  logic [NUM_REQ-1:0]              w_grant;
  logic [W_PORTS_NUM-1:0]          w_port_vld;
  logic [W_PORTS_NUM-1:0][IW-1:0]  w_port_idx;
  logic [IW-1:0]                   w_last_idx;
  logic                            w_any_port;
  logic                            w_coll;
  logic [IW-1:0]                   w_ptr_nxt;
  vrf_wr_req_t                     w_port [W_PORTS_NUM];

  vrf_wr_rr_select #(
    .NUM_REQ     (NUM_REQ),
    .W_PORTS_NUM (W_PORTS_NUM),
    .AW          (AW),
    .NB          (NB),
    .IW          (IW)
  ) u_sel (
    .i_ptr       (r_ptr),
    .i_en        (arb_en_i),
    .i_valid     (req_valid_i),
    .i_addr      (req_addr_i),
    .i_bwe       (req_bwe_i),
    .o_grant     (w_grant),
    .o_port_vld  (w_port_vld),
    .o_port_idx  (w_port_idx),
    .o_last_idx  (w_last_idx),
    .o_any_port  (w_any_port),
    .o_collision (w_coll)
  );

  assign req_ready_o = rstn ? w_grant : '0;
  assign w_ptr_nxt   = (w_last_idx == IW'(NUM_REQ - 1)) ? '0 : w_last_idx + 1'b1;

  // Unused ports are zeroed so the VRF sees bwe=0 and quiet addr/din.
  always_comb begin
    for (int p = 0; p < W_PORTS_NUM; p++) begin
      w_port[p] = '0;
      if (w_port_vld[p])
        w_port[p] = '{addr: req_addr_i[w_port_idx[p]],
                      bwe:  req_bwe_i[w_port_idx[p]],
                      data: req_data_i[w_port_idx[p]]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ptr <= '0;
      r_cnt <= '0;
      for (int p = 0; p < W_PORTS_NUM; p++) r_port[p] <= '0;
    end else begin
      for (int p = 0; p < W_PORTS_NUM; p++) r_port[p] <= w_port[p];
      if (w_any_port) r_ptr <= w_ptr_nxt;
      if (w_coll && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
  end

  always_comb begin
    for (int p = 0; p < W_PORTS_NUM; p++) begin
      vrf_waddr_o[p] = r_port[p].addr;
      vrf_bwe_o[p]   = r_port[p].bwe;
      vrf_din_o[p]   = r_port[p].data;
    end
  end

  assign conflict_cnt_o = r_cnt;

endmodule

// File: doc/vrf_wr_arbiter.md
# vrf_wr_arbiter

Round-robin write-port arbiter in front of the multi-ported vector register file (VRF) in each vector lane. It shares the VRF's W_PORTS_NUM byte-enabled write ports among NUM_REQ write requesters (ALU pipes, load unit, slide/permute unit, etc.). It never grants two writes to the same VRF address in one cycle, because simultaneous same-address writes corrupt the XOR/LVT banks. It drives registered write-port signals into the VRF.

## Interface
- NUM_REQ, 6, number of write requesters (2..16)
- W_PORTS_NUM, 4, number of VRF write ports (1..NUM_REQ)
- MEM_DEPTH, 512, VRF depth per lane; AW = $clog2(MEM_DEPTH)
- MEM_WIDTH, 32, data width; NB = MEM_WIDTH/8 byte enables
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- arb_en_i  in  1  1 = grants allowed; 0 = freeze, no grants
- req_valid_i  in  NUM_REQ  request valid per requester
- req_ready_o  out  NUM_REQ  grant; transfer when valid & ready (combinational)
- req_addr_i  in  NUM_REQ x AW  target VRF address
- req_bwe_i  in  NUM_REQ x NB  byte enables
- req_data_i  in  NUM_REQ x MEM_WIDTH  write data
- vrf_waddr_o  out  W_PORTS_NUM x AW  to VRF waddr_i (registered)
- vrf_bwe_o  out  W_PORTS_NUM x NB  to VRF bwe_i (registered); all-zero = idle port
- vrf_din_o  out  W_PORTS_NUM x MEM_WIDTH  to VRF din_i (registered)
- conflict_cnt_o  out  16  saturating count of cycles in which at least one request was stalled by an address collision

## Operation
- Priority pointer `ptr` (0..NUM_REQ-1). Each cycle, requesters are scanned in order ptr, ptr+1, … mod NUM_REQ.
- A scanned requester with valid=1 is granted only if all of the following hold:
  - arb_en_i=1;
  - a free port remains;
  - its address differs from every requester already granted this cycle.
- Grant order maps to ports: the k-th granted requester takes port k. Ports left unused drive bwe=0 with addr/din held at 0.
- Zero-bwe requests (valid=1, bwe=0): granted whenever arb_en_i=1. They consume no port, are not forwarded and take no part in collision checks.
- Collision-stalled and port-starved requesters keep ready=0. Requesters must hold valid, addr, bwe and data stable until accepted.
- Pointer update:
  - if at least one port-consuming grant occurs, ptr becomes (index of the last port-consuming grantee + 1) mod NUM_REQ;
  - otherwise ptr is unchanged.
- This rule guarantees every continuously valid requester is served within ceil(NUM_REQ/W_PORTS_NUM) grant cycles, excluding collision stalls.
- conflict_cnt_o increments by 1 per cycle with at least one collision stall and saturates at 16'hFFFF.
- arb_en_i=0: all ready=0, every output port idle on the next edge, ptr and counter unchanged.

## Timing
- Reset (rstn=0 at a clk edge): ptr=0, vrf_bwe_o=0, vrf_waddr_o=0, vrf_din_o=0, conflict_cnt_o=0. req_ready_o is forced 0 while rstn=0.
- Latency: a request accepted in cycle N appears on its port in cycle N+1 (one flop stage). The VRF's own write pipeline follows.
- A port idle in cycle N shows bwe=0 in cycle N+1.
- Reset asserted mid-operation: in-flight registered writes are dropped (bwe cleared). Requesters must re-present; accepted state is not replayed.
- Simultaneous events on the same address: the requester earlier in rotation order wins. The loser is considered again next cycle with the updated ptr.
- req_ready_o depends combinationally on req_valid_i, req_addr_i, req_bwe_i, arb_en_i and ptr. It must not depend combinationally on any requester's data.

## Structure
- Shared package vrf_pkg holds:
  - function vrf_aw(depth) returning $clog2;
  - localparam NB derivation;
  - typedef vrf_wr_req_t (addr, bwe, data), used by this block and by requesters.
- Sub-module vrf_wr_rr_select: combinational rotate-scan with port allocation and collision check. It outputs the grant vector, per-port requester index, per-port valid, and last-grantee index. The top level holds ptr, the output registers and the counter.

## Test plan
- Reset: drive all valid=1 with rstn=0 -> ready=0; after release, all outputs 0 and ptr=0.
- Saturation with NUM_REQ=6, W_PORTS_NUM=4, all valid, distinct addrs 0..5:
  - cycle 1 grants requesters 0-3 on ports 0-3;
  - cycle 2 grants 4,5 on ports 0,1, ports 2,3 bwe=0;
  - each request appears once, one cycle after its grant.
- Collision: requesters 1 and 3 both addr 0x10, ptr=0 -> 1 granted, 3 stalled, conflict_cnt_o=1; next cycle 3 is granted.
- Zero-bwe: requester 2 valid with bwe=0 alongside 4 real writes -> all 5 ready=1, only 4 ports driven.
- Freeze: arb_en_i=0 for 3 cycles with requests pending -> ready=0 and ports idle; ptr is unchanged on resume.
- Counter saturation: force 65,540 collision cycles -> conflict_cnt_o holds 16'hFFFF.
